// File: rtl/asroba_pipe_mult.sv
// Three-stage pipelined rounding-based approximate signed multiplier with valid/ready flow control.
// Define ASROBA_EXACT_SIGN_EN for two's complement sign handling; the default build uses one's complement in approximate mode.
module asroba_pipe_mult #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  input  logic                 in_mode,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int KW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH + 2;
  localparam int OW = 2 * WIDTH;

  // Exponent of the magnitude rounded to a power of two; a zero magnitude yields 0 and is flagged downstream.
  function automatic logic [KW-1:0] round_exp(input logic [WIDTH-1:0] mag);
    logic [KW-1:0] m;
    logic          rnd;
    m   = '0;
    rnd = 1'b0;
    for (int i = 1; i < WIDTH; i++) begin
      if (mag[i]) begin
        m   = KW'(i);
        rnd = mag[i-1] && (i >= 2);
      end
    end
    return m + KW'(rnd);
  endfunction

  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic push, adv2, adv3, pop;

  logic [WIDTH-1:0] s1_mx_q, s1_mx_d, s1_my_q, s1_my_d;
  logic [KW-1:0]    s1_kx_q, s1_kx_d, s1_ky_q, s1_ky_d;
  logic             s1_s_q, s1_s_d, s1_mode_q, s1_mode_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

  logic [PW-1:0]    s2_p_q, s2_p_d;
  logic             s2_s_q, s2_s_d, s2_twos_q, s2_twos_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic [OW-1:0]    out_p_q, out_p_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic [WIDTH-1:0] neg_x, neg_y, mag_x, mag_y;
  logic [PW-1:0]    term_a, term_b, term_c, p_approx, p_exact;
  logic [KW:0]      k_sum;
  logic [PW-1:0]    lim;
  logic [OW-1:0]    mag_o, res;

  always_comb begin
    pop      = v3_q & out_ready;
    adv3     = v2_q & (~v3_q | out_ready);
    adv2     = v1_q & (~v2_q | adv3);
    in_ready = ~v1_q | adv2;
    push     = in_valid & in_ready;
    v1_d     = push | (v1_q & ~adv2);
    v2_d     = adv2 | (v2_q & ~adv3);
    v3_d     = adv3 | (v3_q & ~pop);
  end

  always_comb begin
    neg_x = ~in_x + WIDTH'(1);
    neg_y = ~in_y + WIDTH'(1);
`ifdef ASROBA_EXACT_SIGN_EN
    mag_x = in_x[WIDTH-1] ? neg_x : in_x;
    mag_y = in_y[WIDTH-1] ? neg_y : in_y;
`else
    mag_x = in_x[WIDTH-1] ? (in_mode ? neg_x : ~in_x) : in_x;
    mag_y = in_y[WIDTH-1] ? (in_mode ? neg_y : ~in_y) : in_y;
`endif
    s1_mx_d   = s1_mx_q;
    s1_my_d   = s1_my_q;
    s1_kx_d   = s1_kx_q;
    s1_ky_d   = s1_ky_q;
    s1_s_d    = s1_s_q;
    s1_mode_d = s1_mode_q;
    s1_tag_d  = s1_tag_q;
    if (push) begin
      s1_mx_d   = mag_x;
      s1_my_d   = mag_y;
      s1_kx_d   = round_exp(mag_x);
      s1_ky_d   = round_exp(mag_y);
      s1_s_d    = in_x[WIDTH-1] ^ in_y[WIDTH-1];
      s1_mode_d = in_mode;
      s1_tag_d  = in_tag;
    end
  end

  // A zero magnitude rounds to zero, so every term it scales must vanish too.
  always_comb begin
    k_sum    = {1'b0, s1_kx_q} + {1'b0, s1_ky_q};
    term_a   = (s1_mx_q == '0) ? '0 : (PW'(s1_my_q) << s1_kx_q);
    term_b   = (s1_my_q == '0) ? '0 : (PW'(s1_mx_q) << s1_ky_q);
    term_c   = ((s1_mx_q == '0) || (s1_my_q == '0)) ? '0 : (PW'(1) << k_sum);
    p_approx = term_a + term_b - term_c;
    p_exact  = PW'(s1_mx_q) * PW'(s1_my_q);
    s2_p_d    = s2_p_q;
    s2_s_d    = s2_s_q;
    s2_twos_d = s2_twos_q;
    s2_tag_d  = s2_tag_q;
    if (adv2) begin
      s2_p_d   = s1_mode_q ? p_exact : p_approx;
      s2_s_d   = s1_s_q;
      s2_tag_d = s1_tag_q;
`ifdef ASROBA_EXACT_SIGN_EN
      s2_twos_d = 1'b1;
`else
      s2_twos_d = s1_mode_q;
`endif
    end
  end

  always_comb begin
    lim   = s2_s_q ? (PW'(1) << (OW - 1)) : ((PW'(1) << (OW - 1)) - PW'(1));
    mag_o = (s2_p_q > lim) ? lim[OW-1:0] : s2_p_q[OW-1:0];
    res   = mag_o;
    if (s2_s_q) begin
      res = s2_twos_q ? (~mag_o + OW'(1)) : ~mag_o;
    end
    out_p_d   = adv3 ? res : out_p_q;
    out_tag_d = adv3 ? s2_tag_q : out_tag_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      s1_mx_q   <= '0;
      s1_my_q   <= '0;
      s1_kx_q   <= '0;
      s1_ky_q   <= '0;
      s1_s_q    <= 1'b0;
      s1_mode_q <= 1'b0;
      s1_tag_q  <= '0;
      s2_p_q    <= '0;
      s2_s_q    <= 1'b0;
      s2_twos_q <= 1'b0;
      s2_tag_q  <= '0;
      out_p_q   <= '0;
      out_tag_q <= '0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      v3_q      <= v3_d;
      s1_mx_q   <= s1_mx_d;
      s1_my_q   <= s1_my_d;
      s1_kx_q   <= s1_kx_d;
      s1_ky_q   <= s1_ky_d;
      s1_s_q    <= s1_s_d;
      s1_mode_q <= s1_mode_d;
      s1_tag_q  <= s1_tag_d;
      s2_p_q    <= s2_p_d;
      s2_s_q    <= s2_s_d;
      s2_twos_q <= s2_twos_d;
      s2_tag_q  <= s2_tag_d;
      out_p_q   <= out_p_d;
      out_tag_q <= out_tag_d;
    end
  end

  assign out_valid = v3_q;
  assign out_p     = out_p_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_asroba_pipe_mult.sv
// Self-checking bench for asroba_pipe_mult: directed scenarios plus randomized traffic against a queue-based arithmetic model.
module tb_asroba_pipe_mult;
  localparam int W  = 16;
  localparam int TW = 4;
`ifdef ASROBA_EXACT_SIGN_EN
  localparam bit EXS = 1'b1;
`else
  localparam bit EXS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_mode, out_valid, out_ready;
  logic [W-1:0]  in_x, in_y;
  logic [TW-1:0] in_tag, out_tag;
  logic [2*W-1:0] out_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  asroba_pipe_mult #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint round_pow2(input longint a);
    int m;
    if (a == 0) return 0;
    m = 0;
    while ((longint'(1) << (m + 1)) <= a) m++;
    if (m >= 2 && ((a >> (m - 1)) & 1) == 1) return longint'(1) << (m + 1);
    return longint'(1) << m;
  endfunction

  function automatic logic [31:0] model_p(input logic [W-1:0] x, input logic [W-1:0] y, input logic mode);
    longint xs, ys, ax, ay, xr, yr, p, lim, r;
    bit s;
    xs = longint'($signed(x));
    ys = longint'($signed(y));
    if (EXS || mode) begin
      ax = (xs < 0) ? -xs : xs;
      ay = (ys < 0) ? -ys : ys;
    end else begin
      ax = (xs < 0) ? -xs - 1 : xs;
      ay = (ys < 0) ? -ys - 1 : ys;
    end
    if (mode) p = ax * ay;
    else begin
      xr = round_pow2(ax);
      yr = round_pow2(ay);
      p  = xr * ay + yr * ax - xr * yr;
    end
    s   = x[W-1] ^ y[W-1];
    lim = s ? (longint'(1) << 31) : (longint'(1) << 31) - 1;
    if (p > lim) p = lim;
    if (!s) r = p;
    else if (EXS || mode) r = -p;
    else r = -p - 1;
    return r[31:0];
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 9))
      0: v = '0;
      1: v = 16'h8000;
      2: v = 16'hFFFF;
      3: v = 16'h7FFF;
      4: v = 16'($urandom_range(0, 20));
      5: begin v = 16'($urandom_range(0, 20)); v = ~v + 16'd1; end
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  typedef struct {
    logic [31:0]   p;
    logic [TW-1:0] tag;
    int            acc;
    bit            lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  bit   front_seen = 0;
  bit   lat_mode = 0;
  bit   prev_stall = 0;
  logic [31:0]   prev_p;
  logic [TW-1:0] prev_tag;

  // Compare process: every accepted input is modelled and queued; every output is checked against the queue head.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      front_seen = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_p", out_p, prev_p);
        check("hold_tag", out_tag, prev_tag);
      end
      if (out_valid) begin
        if (q.size() == 0) check("spurious_out", out_valid, 0);
        else begin
          check("out_p", out_p, q[0].p);
          check("out_tag", out_tag, q[0].tag);
          if (!front_seen && q[0].lat) check("latency", cyc - q[0].acc, 3);
          front_seen = 1;
        end
      end
      check("in_ready", in_ready, (q.size() < 3) || out_ready);
      prev_stall = out_valid && !out_ready;
      prev_p     = out_p;
      prev_tag   = out_tag;
      if (out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        front_seen = 0;
      end
      if (in_valid && in_ready) begin
        e.p   = model_p(in_x, in_y, in_mode);
        e.tag = in_tag;
        e.acc = cyc;
        e.lat = lat_mode;
        q.push_back(e);
      end
    end
  end

  task automatic drive_rand();
    in_x    = rand_op();
    in_y    = rand_op();
    in_mode = 1'($urandom_range(0, 1));
    in_tag  = TW'($urandom);
  endtask

  task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic mode,
                         input logic [TW-1:0] tag, input logic [31:0] exp, input string name);
    int n;
    in_valid = 1; in_x = x; in_y = y; in_mode = mode; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_lat"}, n, 2);
    check({name, "_p"}, out_p, exp);
    check({name, "_tag"}, out_tag, tag);
  endtask

  initial begin
    int n, acc, nt;
    logic [31:0]   p0;
    logic [TW-1:0] got[$];

    rst = 1; in_valid = 0; in_x = '0; in_y = '0; in_mode = 0; in_tag = '0; out_ready = 1;

    check("model_3x3", model_p(16'd3, 16'd3, 1'b0), 32'd8);
    check("model_6x5_apx", model_p(16'd6, 16'd5, 1'b0), 32'd32);
    check("model_6x5_exact", model_p(16'd6, 16'd5, 1'b1), 32'd30);
    check("model_neg6x5", model_p(16'hFFFA, 16'd5, 1'b0), EXS ? 32'hFFFF_FFE0 : 32'hFFFF_FFE7);
    check("model_min_sq", model_p(16'h8000, 16'h8000, 1'b0), EXS ? 32'd1073741824 : 32'd1073676288);
    check("model_zero", model_p(16'd0, 16'd1234, 1'b0), 32'd0);

    repeat (3) @(posedge clk);
    #1 rst = 0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);

    run_one(16'd3, 16'd3, 1'b0, 4'd1, 32'd8, "t3x3");
    run_one(16'hFFFA, 16'd5, 1'b0, 4'd2, EXS ? 32'hFFFF_FFE0 : 32'hFFFF_FFE7, "tneg6x5");
    run_one(16'h8000, 16'h8000, 1'b0, 4'd3, EXS ? 32'd1073741824 : 32'd1073676288, "tmin_sq");
    run_one(16'd0, 16'd1234, 1'b0, 4'd4, 32'd0, "tzero");

    in_valid = 1; in_x = 16'd6; in_y = 16'd5; in_mode = 0; in_tag = 4'd2;
    @(posedge clk); #1;
    in_mode = 1; in_tag = 4'd3;
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    check("b2b_lat", n, 1);
    check("b2b_first_p", out_p, 32'd32);
    check("b2b_first_tag", out_tag, 4'd2);
    @(posedge clk); #1;
    check("b2b_second_valid", out_valid, 1);
    check("b2b_second_p", out_p, 32'd30);
    check("b2b_second_tag", out_tag, 4'd3);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: consumer stalls while five tagged transactions are offered.
    out_ready = 0; acc = 0; nt = 1;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1; drive_rand(); in_tag = TW'(nt);
      #1;
      if (in_ready) begin acc++; nt++; end
      @(posedge clk); #1;
    end
    check("bp_accepts", acc, 3);
    check("bp_in_ready_low", in_ready, 0);
    p0 = out_p;
    repeat (2) @(posedge clk);
    #1;
    check("bp_hold_p", out_p, p0);
    check("bp_front_tag", out_tag, 4'd1);
    out_ready = 1;
    n = 0;
    while (got.size() < 5 && n < 40) begin
      if (nt <= 5) begin in_valid = 1; drive_rand(); in_tag = TW'(nt); end
      else in_valid = 0;
      #1;
      if (in_valid && in_ready) nt++;
      if (out_valid) got.push_back(out_tag);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 0;
    check("bp_count", got.size(), 5);
    for (int i = 0; i < got.size(); i++) check("bp_order", got[i], TW'(i + 1));
    repeat (4) @(posedge clk);
    #1;

    // Reset with two transactions in flight.
    in_valid = 1; in_x = 16'd7; in_y = 16'd9; in_mode = 0; in_tag = 4'd6;
    @(posedge clk); #1;
    in_tag = 4'd7;
    @(posedge clk); #1;
    in_valid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("mid_rst_no_stale", out_valid, 0);
    end

    // Random traffic, consumer always ready: exact latency is checked per entry.
    lat_mode = 1; out_ready = 1;
    for (int i = 0; i < 300; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      drive_rand();
      @(posedge clk); #1;
    end
    in_valid = 0;
    repeat (6) @(posedge clk);
    #1;
    lat_mode = 0;

    // Random traffic with random backpressure.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      drive_rand();
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    repeat (10) @(posedge clk);
    #1;
    check("drain_empty", q.size(), 0);
    check("drain_out_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
